// File: rtl/dcache_req_arbiter_pkg.sv
// BoomLSUST: shared dcache request/response types and arbiter defaults.
// Imported by the arbiter, its output slot and the request interface.
package BoomLSUST;

   typedef logic [3:0] HellaCntT;

   localparam int HELLA_MAX_INFLIGHT_DEF = 1;
   localparam int STARVE_LIMIT_DEF       = 8;

   typedef struct packed {
      logic [39:0] addr;
      logic [63:0] data;
      logic [4:0]  cmd;
      logic [1:0]  size;
      logic [7:0]  tag;
      logic        is_hella;
   } BoomDCacheReqST;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  tag;
      logic        is_hella;
   } BoomDCacheRespST;

endpackage

// File: rtl/dcache_req_arbiter_if.sv
// Valid/ready request channel carrying a BoomDCacheReqST payload.
// master drives valid/bits and samples ready; slave the reverse.
interface dcache_req_arbiter_if;
   import BoomLSUST::*;

   logic           valid;
   logic           ready;
   BoomDCacheReqST bits;

   modport master (output valid, output bits, input ready);
   modport slave  (input valid, input bits, output ready);

endinterface

// File: rtl/dcache_req_slot.sv
// Single-entry registered valid/ready slot for dcache requests.
// Ports: clock, reset, enq_valid/enq_ready/enq_bits, deq_valid/deq_ready/deq_bits.
module dcache_req_slot
   import BoomLSUST::*;
(
   input  logic           clock,
   input  logic           reset,
   input  logic           enq_valid,
   output logic           enq_ready,
   input  BoomDCacheReqST enq_bits,
   output logic           deq_valid,
   input  logic           deq_ready,
   output BoomDCacheReqST deq_bits
);

   logic           slot_v;
   BoomDCacheReqST slot_q;

   // Free when empty, or when the held entry leaves this cycle.
   assign enq_ready = !slot_v || deq_ready;
   assign deq_valid = slot_v;
   assign deq_bits  = slot_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         slot_v <= 1'b0;
         slot_q <= '0;
      end else if (enq_valid && enq_ready) begin
         slot_v <= 1'b1;
         slot_q <= enq_bits;
      end else if (deq_ready) begin
         slot_v <= 1'b0;
      end
   end

endmodule

// File: rtl/dcache_req_arbiter.sv
// Shares the dcache request port between LSU and hella (PTW/RoCC) with
// LSU priority, hella anti-starvation and a hella inflight limit.
// Ports: clock, reset; lsu/hella (slave req), dc (master req);
// dc_resp*, dc_nack*; lsu_resp*, hella_resp*; hella_inflight.
module dcache_req_arbiter
   import BoomLSUST::*;
#(
   parameter int HELLA_MAX_INFLIGHT = HELLA_MAX_INFLIGHT_DEF,
   parameter int STARVE_LIMIT       = STARVE_LIMIT_DEF
) (
   input  logic                  clock,
   input  logic                  reset,
   dcache_req_arbiter_if.slave   lsu,
   dcache_req_arbiter_if.slave   hella,
   dcache_req_arbiter_if.master  dc,
   input  logic                  dc_resp_valid,
   input  BoomDCacheRespST       dc_resp,
   input  logic                  dc_nack_valid,
   input  logic                  dc_nack_is_hella,
   output logic                  lsu_resp_valid,
   output BoomDCacheRespST       lsu_resp,
   output logic                  hella_resp_valid,
   output BoomDCacheRespST       hella_resp,
   output HellaCntT              hella_inflight
);

   localparam HellaCntT  MAX_C = HellaCntT'(HELLA_MAX_INFLIGHT);
   localparam logic [7:0] LIM_C = 8'(STARVE_LIMIT);

   logic           free;
   logic           cnt_ok;
   logic           hella_ok;
   logic           hella_pri;
   logic           grant_l;
   logic           grant_h;
   logic           dec_r;
   logic           dec_n;
   BoomDCacheReqST grant_bits;

   logic [7:0]     starve_cnt;
   logic [7:0]     starve_nxt;
   HellaCntT       inflight_q;
   HellaCntT       inflight_nxt;

   assign cnt_ok    = inflight_q < MAX_C;
   assign hella_ok  = hella.valid && cnt_ok;
   assign hella_pri = starve_cnt == LIM_C;

   assign grant_h = free && hella_ok && (hella_pri || !lsu.valid);
   assign grant_l = free && lsu.valid && !(hella_pri && hella_ok);

   // Readies never look at their own requester's valid.
   assign lsu.ready   = free && !(hella_pri && hella_ok);
   assign hella.ready = free && cnt_ok && (hella_pri || !lsu.valid);

   always_comb begin
      grant_bits          = lsu.bits;
      grant_bits.is_hella = 1'b0;
      if (grant_h) begin
         grant_bits          = hella.bits;
         grant_bits.is_hella = 1'b1;
      end
   end

   dcache_req_slot u_slot (
      .clock     (clock),
      .reset     (reset),
      .enq_valid (grant_l || grant_h),
      .enq_ready (free),
      .enq_bits  (grant_bits),
      .deq_valid (dc.valid),
      .deq_ready (dc.ready),
      .deq_bits  (dc.bits)
   );

   // Counts only the cycles where hella could have gone but LSU won.
   always_comb begin
      starve_nxt = starve_cnt;
      if (grant_h || !hella.valid) begin
         starve_nxt = '0;
      end else if (hella_ok && grant_l && starve_cnt != LIM_C) begin
         starve_nxt = starve_cnt + 8'd1;
      end
   end

   assign dec_r = dc_resp_valid && dc_resp.is_hella;
   assign dec_n = dc_nack_valid && dc_nack_is_hella;

   // Net per-cycle change; grant plus retire cancels out.
   always_comb begin
      inflight_nxt = inflight_q
                   + HellaCntT'(grant_h)
                   - HellaCntT'(dec_r)
                   - HellaCntT'(dec_n);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         starve_cnt <= '0;
         inflight_q <= '0;
      end else begin
         starve_cnt <= starve_nxt;
         inflight_q <= inflight_nxt;
      end
   end

   assign hella_inflight = inflight_q;

   assign lsu_resp_valid   = dc_resp_valid && !dc_resp.is_hella;
   assign hella_resp_valid = dc_resp_valid && dc_resp.is_hella;
   assign lsu_resp         = dc_resp;
   assign hella_resp       = dc_resp;

   a_no_underflow: assert property (
      @(posedge clock) disable iff (reset)
      !(inflight_q == '0 && (dec_r || dec_n))
   );

   a_stable_payload: assert property (
      @(posedge clock) disable iff (reset)
      (dc.valid && !dc.ready) |=> $stable(dc.bits)
   );

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Scoreboard bench for dcache_req_arbiter: directed stimulus pushes
// expected dcache grants; a negedge monitor pops and compares them.
module tb_dcache_req_arbiter;
   import BoomLSUST::*;

   typedef struct {
      logic [39:0] addr;
      logic        is_hella;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   dcache_req_arbiter_if lsu_if ();
   dcache_req_arbiter_if hella_if ();
   dcache_req_arbiter_if dc_if ();
   logic            dc_resp_valid;
   BoomDCacheRespST dc_resp;
   logic            dc_nack_valid, dc_nack_is_hella;
   logic            lsu_resp_valid, hella_resp_valid;
   BoomDCacheRespST lsu_resp, hella_resp;
   HellaCntT        hella_inflight;

   dcache_req_arbiter_if lsu2_if ();
   dcache_req_arbiter_if hella2_if ();
   dcache_req_arbiter_if dc2_if ();
   logic            dc2_resp_valid;
   BoomDCacheRespST dc2_resp;
   logic            lsu2_resp_valid, hella2_resp_valid;
   BoomDCacheRespST lsu2_resp, hella2_resp;
   HellaCntT        hella2_inflight;

   dcache_req_arbiter #(
      .HELLA_MAX_INFLIGHT (1),
      .STARVE_LIMIT       (8)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .lsu              (lsu_if),
      .hella            (hella_if),
      .dc               (dc_if),
      .dc_resp_valid    (dc_resp_valid),
      .dc_resp          (dc_resp),
      .dc_nack_valid    (dc_nack_valid),
      .dc_nack_is_hella (dc_nack_is_hella),
      .lsu_resp_valid   (lsu_resp_valid),
      .lsu_resp         (lsu_resp),
      .hella_resp_valid (hella_resp_valid),
      .hella_resp       (hella_resp),
      .hella_inflight   (hella_inflight)
   );

   dcache_req_arbiter #(
      .HELLA_MAX_INFLIGHT (2),
      .STARVE_LIMIT       (8)
   ) dut2 (
      .clock            (clock),
      .reset            (reset),
      .lsu              (lsu2_if),
      .hella            (hella2_if),
      .dc               (dc2_if),
      .dc_resp_valid    (dc2_resp_valid),
      .dc_resp          (dc2_resp),
      .dc_nack_valid    (1'b0),
      .dc_nack_is_hella (1'b0),
      .lsu_resp_valid   (lsu2_resp_valid),
      .lsu_resp         (lsu2_resp),
      .hella_resp_valid (hella2_resp_valid),
      .hella_resp       (hella2_resp),
      .hella_inflight   (hella2_inflight)
   );

   int   ntests = 0;
   int   nfail  = 0;
   exp_t q[$];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [39:0] a, input logic h);
      exp_t e;
      e.addr     = a;
      e.is_hella = h;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (!reset && dc_if.valid && dc_if.ready) begin
         if (q.size() == 0) begin
            ntests++;
            nfail++;
            $display("FAIL dc_unexpected: got addr %0h expected none",
                     dc_if.bits.addr);
         end else begin
            e = q.pop_front();
            chk("dc_addr", 64'(dc_if.bits.addr), 64'(e.addr));
            chk("dc_is_hella", 64'(dc_if.bits.is_hella), 64'(e.is_hella));
         end
      end
   end

   initial begin
      lsu_if.valid     = 1'b0;
      lsu_if.bits      = '0;
      hella_if.valid   = 1'b0;
      hella_if.bits    = '0;
      dc_if.ready      = 1'b0;
      dc_resp_valid    = 1'b0;
      dc_resp          = '0;
      dc_nack_valid    = 1'b0;
      dc_nack_is_hella = 1'b0;
      lsu2_if.valid    = 1'b0;
      lsu2_if.bits     = '0;
      hella2_if.valid  = 1'b0;
      hella2_if.bits   = '0;
      dc2_if.ready     = 1'b1;
      dc2_resp_valid   = 1'b0;
      dc2_resp         = '0;

      // reset state
      @(negedge clock);
      chk("rst_dc_valid", 64'(dc_if.valid), 64'd0);
      chk("rst_inflight", 64'(hella_inflight), 64'd0);
      chk("rst_lsu_ready", 64'(lsu_if.ready), 64'd1);
      chk("rst_hella_ready", 64'(hella_if.ready), 64'd1);
      lsu_if.valid = 1'b1;
      #1;
      chk("rst_hella_ready_lsu_busy", 64'(hella_if.ready), 64'd0);
      lsu_if.valid = 1'b0;
      tick();
      reset       = 1'b0;
      dc_if.ready = 1'b1;

      // starvation: LSU wins 8 cycles, hella takes the 9th
      for (int i = 0; i < 9; i++) begin
         lsu_if.valid        = 1'b1;
         lsu_if.bits.addr    = 40'h1000 + 40'(i * 8);
         hella_if.valid      = 1'b1;
         hella_if.bits.addr  = 40'h2000;
         @(negedge clock);
         chk("starve_lsu_ready", 64'(lsu_if.ready), 64'(i < 8));
         chk("starve_hella_ready", 64'(hella_if.ready), 64'(i == 8));
         if (i < 8) push(40'h1000 + 40'(i * 8), 1'b0);
         else       push(40'h2000, 1'b1);
         tick();
      end
      lsu_if.valid   = 1'b0;
      hella_if.valid = 1'b0;
      @(negedge clock);
      chk("starve_cnt_clear", 64'(dut.starve_cnt), 64'd0);
      chk("starve_inflight", 64'(hella_inflight), 64'd1);

      // inflight limit, then hella response frees it
      tick();
      hella_if.valid     = 1'b1;
      hella_if.bits.addr = 40'h2100;
      @(negedge clock);
      chk("limit_hella_ready", 64'(hella_if.ready), 64'd0);
      tick();
      dc_resp_valid    = 1'b1;
      dc_resp.is_hella = 1'b1;
      dc_resp.data     = 64'h1234;
      @(negedge clock);
      chk("hresp_hella_valid", 64'(hella_resp_valid), 64'd1);
      chk("hresp_lsu_valid", 64'(lsu_resp_valid), 64'd0);
      chk("hresp_data", hella_resp.data, 64'h1234);
      chk("hresp_hella_ready", 64'(hella_if.ready), 64'd0);
      tick();
      dc_resp_valid = 1'b0;
      @(negedge clock);
      chk("hresp_inflight", 64'(hella_inflight), 64'd0);
      chk("hresp_reissue_ready", 64'(hella_if.ready), 64'd1);
      push(40'h2100, 1'b1);
      tick();
      hella_if.valid = 1'b0;
      @(negedge clock);
      chk("reissue_inflight", 64'(hella_inflight), 64'd1);

      // nacks: only hella nacks retire
      tick();
      dc_nack_valid    = 1'b1;
      dc_nack_is_hella = 1'b0;
      tick();
      @(negedge clock);
      chk("lsu_nack_inflight", 64'(hella_inflight), 64'd1);
      tick();
      dc_nack_is_hella = 1'b1;
      tick();
      dc_nack_valid = 1'b0;
      @(negedge clock);
      chk("hella_nack_inflight", 64'(hella_inflight), 64'd0);

      // back-pressure
      tick();
      dc_if.ready      = 1'b0;
      lsu_if.valid     = 1'b1;
      lsu_if.bits.addr = 40'h80001000;
      @(negedge clock);
      chk("bp_accept_ready", 64'(lsu_if.ready), 64'd1);
      push(40'h80001000, 1'b0);
      tick();
      lsu_if.bits.addr = 40'h80002000;
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         chk("bp_dc_valid", 64'(dc_if.valid), 64'd1);
         chk("bp_dc_addr", 64'(dc_if.bits.addr), 64'h80001000);
         chk("bp_lsu_ready", 64'(lsu_if.ready), 64'd0);
         chk("bp_hella_ready", 64'(hella_if.ready), 64'd0);
         tick();
      end
      dc_if.ready = 1'b1;
      @(negedge clock);
      chk("bp_release_ready", 64'(lsu_if.ready), 64'd1);
      push(40'h80002000, 1'b0);
      tick();
      lsu_if.valid = 1'b0;
      @(negedge clock);
      chk("bp_next_valid", 64'(dc_if.valid), 64'd1);

      // response steering to LSU
      tick();
      dc_resp_valid    = 1'b1;
      dc_resp.is_hella = 1'b0;
      dc_resp.data     = 64'hDEADBEEF;
      #1;
      chk("lresp_lsu_valid", 64'(lsu_resp_valid), 64'd1);
      chk("lresp_hella_valid", 64'(hella_resp_valid), 64'd0);
      chk("lresp_data", lsu_resp.data, 64'hDEADBEEF);
      tick();
      dc_resp_valid = 1'b0;

      // asynchronous reset with the slot full
      dc_if.ready        = 1'b0;
      hella_if.valid     = 1'b1;
      hella_if.bits.addr = 40'h2200;
      @(negedge clock);
      chk("pre_rst_hella_ready", 64'(hella_if.ready), 64'd1);
      tick();
      hella_if.valid = 1'b0;
      @(negedge clock);
      chk("pre_rst_dc_valid", 64'(dc_if.valid), 64'd1);
      chk("pre_rst_is_hella", 64'(dc_if.bits.is_hella), 64'd1);
      chk("pre_rst_inflight", 64'(hella_inflight), 64'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("async_rst_dc_valid", 64'(dc_if.valid), 64'd0);
      chk("async_rst_inflight", 64'(hella_inflight), 64'd0);
      tick();
      tick();
      reset            = 1'b0;
      dc_if.ready      = 1'b1;
      lsu_if.valid     = 1'b1;
      lsu_if.bits.addr = 40'h3000;
      @(negedge clock);
      chk("post_rst_lsu_ready", 64'(lsu_if.ready), 64'd1);
      push(40'h3000, 1'b0);
      tick();
      lsu_if.valid = 1'b0;

      // limit 2: grant and hella response in one cycle
      hella2_if.valid     = 1'b1;
      hella2_if.bits.addr = 40'h5000;
      @(negedge clock);
      chk("h2_ready_first", 64'(hella2_if.ready), 64'd1);
      tick();
      dc2_resp_valid    = 1'b1;
      dc2_resp.is_hella = 1'b1;
      @(negedge clock);
      chk("h2_inflight_one", 64'(hella2_inflight), 64'd1);
      chk("h2_ready_second", 64'(hella2_if.ready), 64'd1);
      chk("h2_resp_valid", 64'(hella2_resp_valid), 64'd1);
      tick();
      hella2_if.valid = 1'b0;
      dc2_resp_valid  = 1'b0;
      @(negedge clock);
      chk("h2_inflight_net", 64'(hella2_inflight), 64'd1);

      for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clock);
      chk("sb_empty", 64'(q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
